// File: rtl/xs_axi4_pkg.sv
// Shared types and constants for the AXI4 read-response memory model.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package xs_axi4_pkg;

  // Default field widths of the AR request record; the top's ID_W/ADDR_W default to these.
  localparam int XS_ID_W   = 14;
  localparam int XS_ADDR_W = 48;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [XS_ID_W-1:0]   id;
    logic [XS_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } xs_rd_state_e;

endpackage

// File: rtl/xs_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth.
// Latency: a pushed entry appears on rd_dat the cycle after the push edge.
// Backpressure: push ignored while full (a same-cycle pop does not make room); pop ignored while empty.
module xs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign rd_dat = mem[rd_ptr];

  // Entry storage; not reset, only the occupancy matters.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/xs_axi4_mem_rd_resp.sv
// AXI4 read responder: queues AR bursts, returns R beats in order from a preloadable beat RAM.
// Latency: first beat valid LATENCY+2 cycles after the AR handshake, then one beat per cycle.
// Backpressure: rready low holds the current beat stable; arready drops while the AR queue is full.
module xs_axi4_mem_rd_resp
  import xs_axi4_pkg::*;
#(
  parameter int              ADDR_W     = XS_ADDR_W,
  parameter int              DATA_W     = 256,
  parameter int              ID_W       = XS_ID_W,
  parameter int              DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 48'h8000_0000,
  parameter int              LATENCY    = 2,
  parameter int              AR_DEPTH   = 4
) (
  input  logic                  io_clock,
  input  logic                  io_reset_n,
  input  logic                  memory_arvalid,
  output logic                  memory_arready,
  input  logic [ID_W-1:0]       memory_arid,
  input  logic [ADDR_W-1:0]     memory_araddr,
  input  logic [7:0]            memory_arlen,
  input  logic [2:0]            memory_arsize,
  input  logic [1:0]            memory_arburst,
  output logic                  memory_rvalid,
  input  logic                  memory_rready,
  output logic [ID_W-1:0]       memory_rid,
  output logic [DATA_W-1:0]     memory_rdata,
  output logic [1:0]            memory_rresp,
  output logic                  memory_rlast,
  input  logic                  preload_en,
  input  logic [DEPTH_LOG2-1:0] preload_idx,
  input  logic [DATA_W-1:0]     preload_data
);

  localparam int BEAT_SHIFT = $clog2(DATA_W / 8);

  xs_rd_state_e state_q, state_d;

  logic              run_q;
  logic              q_full, q_empty, q_pop;
  ar_req_t           q_in, q_head, cur_q;
  logic [3:0]        wait_q;
  logic [7:0]        beat_q;      // number of beats already loaded into the R stage
  logic              beat_cap;    // load the next beat into the R stage
  logic              last_hs;     // final beat of the burst accepted
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] beat_idx;
  logic              bad_fmt;
  logic              bad_addr;
  logic [DATA_W-1:0] ram [2**DEPTH_LOG2];

  // arready comes from registers only: the run flag and the queue occupancy.
  assign memory_arready = run_q && !q_full;

  assign q_in.id    = memory_arid;
  assign q_in.addr  = memory_araddr;
  assign q_in.len   = memory_arlen;
  assign q_in.size  = memory_arsize;
  assign q_in.burst = memory_arburst;

  xs_sync_fifo #(
    .WIDTH ($bits(ar_req_t)),
    .DEPTH (AR_DEPTH)
  ) u_ar_q (
    .clk    (io_clock),
    .rst_n  (io_reset_n),
    .wr_vld (memory_arvalid && memory_arready),
    .wr_dat (q_in),
    .rd_rdy (q_pop),
    .rd_dat (q_head),
    .empty  (q_empty),
    .full   (q_full)
  );

  // Index is computed wide so a burst running off the end is seen as out of range, never wrapped.
  assign off      = cur_q.addr - BASE_ADDR;
  assign beat_idx = (off >> BEAT_SHIFT) + ADDR_W'(beat_q);
  assign bad_fmt  = (cur_q.size != 3'(BEAT_SHIFT)) || (cur_q.burst != BURST_INCR);
  assign bad_addr = (cur_q.addr < BASE_ADDR) || (|beat_idx[ADDR_W-1:DEPTH_LOG2]);

  // Run flag keeps arready low for the cycle(s) the block is held in reset.
  always_ff @(posedge io_clock) begin
    run_q <= io_reset_n;
  end

  // FSM state register.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // FSM next-state: IDLE pops, WAIT counts down LATENCY, BURST runs until the last beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!q_empty) state_d = (LATENCY == 0) ? ST_BURST : ST_WAIT;
      ST_WAIT:  if (wait_q <= 4'd1) state_d = ST_BURST;
      ST_BURST: if (last_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the R stage is reloaded when empty or when a non-final beat is accepted.
  always_comb begin
    q_pop    = 1'b0;
    beat_cap = 1'b0;
    last_hs  = 1'b0;
    case (state_q)
      ST_IDLE:  q_pop = !q_empty;
      ST_BURST: begin
        beat_cap = !memory_rvalid || (memory_rready && !memory_rlast);
        last_hs  = memory_rvalid && memory_rready && memory_rlast;
      end
      default: ;
    endcase
  end

  // Burst context: latch the popped request, count down the wait, count loaded beats.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      cur_q  <= '0;
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      if (q_pop) begin
        cur_q  <= q_head;
        wait_q <= 4'(LATENCY);
        beat_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wait_q <= wait_q - 4'd1;
      end
      if (beat_cap) beat_q <= beat_q + 8'd1;
    end
  end

  // Backdoor RAM write; a read at the same edge sees the previous contents.
  always_ff @(posedge io_clock) begin
    if (preload_en) ram[preload_idx] <= preload_data;
  end

  // R output stage: registered RAM read with error substitution, held while stalled.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      memory_rvalid <= 1'b0;
      memory_rid    <= '0;
      memory_rdata  <= '0;
      memory_rresp  <= RESP_OKAY;
      memory_rlast  <= 1'b0;
    end else if (beat_cap) begin
      memory_rvalid <= 1'b1;
      memory_rid    <= cur_q.id;
      memory_rlast  <= (beat_q == cur_q.len);
      if (bad_fmt) begin
        memory_rresp <= RESP_SLVERR;
        memory_rdata <= '0;
      end else if (bad_addr) begin
        memory_rresp <= RESP_DECERR;
        memory_rdata <= '0;
      end else begin
        memory_rresp <= RESP_OKAY;
        memory_rdata <= ram[beat_idx[DEPTH_LOG2-1:0]];
      end
    end else if (last_hs) begin
      memory_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xs_axi4_mem_rd_resp.sv
// Bench for xs_axi4_mem_rd_resp: shadow-RAM beat model plus directed and random bursts.
module tb_xs_axi4_mem_rd_resp;

  localparam int          ID_W   = 14;
  localparam int          DATA_W = 256;
  localparam int          DL2    = 12;
  localparam int          NBEATS = 1 << DL2;
  localparam logic [47:0] BASE   = 48'h8000_0000;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  logic              io_clock = 1'b0;
  logic              io_reset_n;
  logic              memory_arvalid;
  logic              memory_arready;
  logic [ID_W-1:0]   memory_arid;
  logic [47:0]       memory_araddr;
  logic [7:0]        memory_arlen;
  logic [2:0]        memory_arsize;
  logic [1:0]        memory_arburst;
  logic              memory_rvalid;
  logic              memory_rready;
  logic [ID_W-1:0]   memory_rid;
  logic [DATA_W-1:0] memory_rdata;
  logic [1:0]        memory_rresp;
  logic              memory_rlast;
  logic              preload_en;
  logic [DL2-1:0]    preload_idx;
  logic [DATA_W-1:0] preload_data;

  xs_axi4_mem_rd_resp dut (
    .io_clock       (io_clock),
    .io_reset_n     (io_reset_n),
    .memory_arvalid (memory_arvalid),
    .memory_arready (memory_arready),
    .memory_arid    (memory_arid),
    .memory_araddr  (memory_araddr),
    .memory_arlen   (memory_arlen),
    .memory_arsize  (memory_arsize),
    .memory_arburst (memory_arburst),
    .memory_rvalid  (memory_rvalid),
    .memory_rready  (memory_rready),
    .memory_rid     (memory_rid),
    .memory_rdata   (memory_rdata),
    .memory_rresp   (memory_rresp),
    .memory_rlast   (memory_rlast),
    .preload_en     (preload_en),
    .preload_idx    (preload_idx),
    .preload_data   (preload_data)
  );

  always #5 io_clock = ~io_clock;

  int cyc = 0;
  always @(posedge io_clock) cyc <= cyc + 1;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] shadow [NBEATS];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_hs = 0;
  int                last_rlast_cyc = 0;
  int                rr_mode = 0;       // 0 fixed, 1 pattern 1,0,0,1, 2 random
  logic              rr_fixed = 1'b0;
  int                rr_ph = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Expected beat b of a burst, straight from the response rules.
  function automatic beat_t model_beat(input logic [ID_W-1:0] id, input logic [47:0] addr,
                                       input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input int b);
    beat_t           r;
    logic [47:0]     o;
    longint unsigned idx;
    r.id   = id;
    r.last = (b == int'(len));
    r.data = '0;
    o      = addr - BASE;
    idx    = 64'(o >> 5) + 64'(b);
    if (size != 3'd5 || burst != 2'b01)   r.resp = 2'b10;
    else if (addr < BASE)                 r.resp = 2'b11;
    else if (idx >= 64'(NBEATS))          r.resp = 2'b11;
    else begin
      r.resp = 2'b00;
      r.data = shadow[idx[DL2-1:0]];
    end
    return r;
  endfunction

  task automatic preload(input int idx, input logic [DATA_W-1:0] d);
    preload_en   = 1'b1;
    preload_idx  = DL2'(idx);
    preload_data = d;
    tick();
    preload_en   = 1'b0;
    shadow[idx]  = d;
  endtask

  // Holds arvalid until accepted; expected beats are queued at the handshake edge.
  task automatic send_ar(input logic [ID_W-1:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
    logic ok;
    int   budget;
    memory_arvalid = 1'b1;
    memory_arid    = id;
    memory_araddr  = addr;
    memory_arlen   = len;
    memory_arsize  = size;
    memory_arburst = burst;
    ok     = 1'b0;
    budget = 0;
    while (!ok && budget < 2000) begin
      @(negedge io_clock);
      ok = memory_arready;
      tick();
      budget++;
    end
    memory_arvalid = 1'b0;
    hs_cyc = 0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ar_accept: id %0h not accepted within %0d cycles, want accepted", id, budget);
    end else begin
      hs_cyc = cyc;
      for (int b = 0; b <= int'(len); b++) exp_q.push_back(model_beat(id, addr, len, size, burst, b));
    end
  endtask

  task automatic wait_drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 4000) begin
      tick();
      b++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  // rready driver: the only process that writes memory_rready.
  initial begin
    memory_rready = 1'b0;
    forever begin
      @(posedge io_clock);
      #1;
      case (rr_mode)
        1: begin
          memory_rready = (rr_ph % 4 == 0) || (rr_ph % 4 == 3);
          rr_ph++;
        end
        2:       memory_rready = ($urandom_range(0, 1) == 1);
        default: memory_rready = rr_fixed;
      endcase
    end
  end

  // Monitor: every accepted beat against the model, and stall stability.
  initial begin
    beat_t             e;
    logic              stall_prev;
    logic [ID_W-1:0]   p_id;
    logic [DATA_W-1:0] p_data;
    logic [1:0]        p_resp;
    logic              p_last;
    stall_prev = 1'b0;
    p_id = '0; p_data = '0; p_resp = '0; p_last = 1'b0;
    forever begin
      @(negedge io_clock);
      if (io_reset_n === 1'b1 && stall_prev) begin
        check("stall_rvalid", 256'(memory_rvalid), 256'(1'b1));
        check("stall_rid",    256'(memory_rid),    256'(p_id));
        check("stall_rdata",  memory_rdata,        p_data);
        check("stall_rresp",  256'(memory_rresp),  256'(p_resp));
        check("stall_rlast",  256'(memory_rlast),  256'(p_last));
      end
      stall_prev = (io_reset_n === 1'b1) && memory_rvalid && !memory_rready;
      p_id   = memory_rid;
      p_data = memory_rdata;
      p_resp = memory_rresp;
      p_last = memory_rlast;
      if (io_reset_n === 1'b1 && memory_rvalid && memory_rready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got rid %0h rresp %0d, want no beat", memory_rid, memory_rresp);
        end else begin
          e = exp_q.pop_front();
          check("beat_rid",   256'(memory_rid),   256'(e.id));
          check("beat_rdata", memory_rdata,       e.data);
          check("beat_rresp", 256'(memory_rresp), 256'(e.resp));
          check("beat_rlast", 256'(memory_rlast), 256'(e.last));
        end
        n_hs++;
        if (memory_rlast) last_rlast_cyc = cyc + 1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int                t, t6, seen, h0, idx, lo, sel;
    logic [47:0]       addr;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [DATA_W-1:0] oldv, newv;
    beat_t             bt;

    io_reset_n     = 1'b0;
    memory_arvalid = 1'b0;
    memory_arid    = '0;
    memory_araddr  = '0;
    memory_arlen   = '0;
    memory_arsize  = 3'd5;
    memory_arburst = 2'b01;
    preload_en     = 1'b0;
    preload_idx    = '0;
    preload_data   = '0;

    // Reset values.
    repeat (3) tick();
    @(negedge io_clock);
    check("rst_arready", 256'(memory_arready), 256'(1'b0));
    check("rst_rvalid",  256'(memory_rvalid),  256'(1'b0));
    check("rst_rid",     256'(memory_rid),     256'(0));
    check("rst_rdata",   memory_rdata,         256'(0));
    check("rst_rresp",   256'(memory_rresp),   256'(0));
    check("rst_rlast",   256'(memory_rlast),   256'(1'b0));
    tick();
    io_reset_n = 1'b1;
    tick();
    check("post_rst_arready", 256'(memory_arready), 256'(1'b1));

    for (int i = 0; i < NBEATS; i++) preload(i, rand256());
    for (int i = 0; i < 4; i++) preload(i, 256'hA0 + 256'(i));

    // Literal pins on the model itself.
    bt = model_beat(14'd5, BASE, 8'd3, 3'd5, 2'b01, 0);
    check("pin_idx0_data", bt.data, 256'hA0);
    bt = model_beat(14'd5, BASE, 8'd3, 3'd5, 2'b01, 3);
    check("pin_idx3_data", bt.data, 256'hA3);
    bt = model_beat(14'd9, BASE + 48'd4094 * 48'd32, 8'd3, 3'd5, 2'b01, 1);
    check("pin_end_ok", 256'(bt.resp), 256'(2'b00));
    bt = model_beat(14'd9, BASE + 48'd4094 * 48'd32, 8'd3, 3'd5, 2'b01, 2);
    check("pin_end_decerr", 256'(bt.resp), 256'(2'b11));
    bt = model_beat(14'd10, 48'h7FFF_FFE0, 8'd0, 3'd5, 2'b01, 0);
    check("pin_below_decerr", 256'(bt.resp), 256'(2'b11));
    bt = model_beat(14'd11, BASE, 8'd1, 3'd3, 2'b01, 1);
    check("pin_size_slverr", 256'(bt.resp), 256'(2'b10));

    // Basic burst with rready high: first rvalid 4 cycles after the AR edge.
    rr_fixed = 1'b1;
    tick();
    send_ar(14'd5, BASE, 8'd3, 3'd5, 2'b01, t);
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge io_clock);
      if (memory_rvalid) begin
        seen = k;
        break;
      end
    end
    check("first_beat_latency", 256'(seen), 256'(4));
    check("first_beat_rdata", memory_rdata, 256'hA0);
    wait_drain("basic");

    // Same burst with rready toggling 1,0,0,1.
    rr_mode = 1;
    send_ar(14'd6, BASE, 8'd3, 3'd5, 2'b01, t);
    wait_drain("toggle");
    rr_mode = 0;

    // Queue fill with rready low: one burst in flight plus a full queue.
    rr_fixed = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) send_ar(ID_W'(i), BASE + 48'(i) * 48'd64, 8'd1, 3'd5, 2'b01, t);
    @(negedge io_clock);
    check("full_arready", 256'(memory_arready), 256'(1'b0));
    fork
      send_ar(14'd6, BASE + 48'd640, 8'd1, 3'd5, 2'b01, t6);
      begin
        repeat (8) tick();
        rr_fixed = 1'b1;
      end
    join
    check("sixth_ar_after_rlast", 256'(t6 - last_rlast_cyc), 256'(2));
    wait_drain("fill");

    // Error responses with random backpressure.
    rr_mode = 2;
    send_ar(14'd9, BASE + 48'd4094 * 48'd32, 8'd3, 3'd5, 2'b01, t);
    send_ar(14'd10, 48'h7FFF_FFE0, 8'd0, 3'd5, 2'b01, t);
    send_ar(14'd11, BASE, 8'd1, 3'd3, 2'b01, t);
    send_ar(14'd12, BASE + 48'd32, 8'd2, 3'd5, 2'b10, t);
    wait_drain("errors");
    rr_mode = 0;

    // Preload colliding with the capture edge returns old data; a re-read sees the new data.
    rr_fixed = 1'b1;
    tick();
    oldv = shadow[7];
    newv = rand256();
    send_ar(14'd13, BASE + 48'd7 * 48'd32, 8'd0, 3'd5, 2'b01, t);
    repeat (3) tick();
    preload(7, newv);
    wait_drain("collide");
    bt = model_beat(14'd13, BASE + 48'd7 * 48'd32, 8'd0, 3'd5, 2'b01, 0);
    check("pin_idx7_new", bt.data, newv);
    send_ar(14'd14, BASE + 48'd7 * 48'd32, 8'd0, 3'd5, 2'b01, t);
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge io_clock);
      if (memory_rvalid) begin
        seen = k;
        break;
      end
    end
    check("reread_new_data", memory_rdata, newv);
    check("collide_old_differs", 256'(oldv != newv), 256'(1'b1));
    wait_drain("reread");

    // Random bursts.
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      lo  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 0;
      if (sel == 0) addr = BASE - 48'($urandom_range(1, 4)) * 48'd32;
      else begin
        idx  = (sel == 1) ? int'($urandom_range(4088, 4095)) : int'($urandom_range(0, 4095));
        addr = BASE + 48'(idx) * 48'd32 + 48'(lo);
      end
      size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd5;
      burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 2) : 2'b01;
      send_ar(ID_W'($urandom_range(0, 16383)), addr, 8'($urandom_range(0, 7)), size, burst, t);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain("random");
    rr_mode = 0;

    // Reset in the middle of an 8-beat burst.
    rr_fixed = 1'b1;
    tick();
    h0 = n_hs;
    send_ar(14'd20, BASE + 48'd100 * 48'd32, 8'd7, 3'd5, 2'b01, t);
    for (int k = 0; k < 200 && n_hs < h0 + 2; k++) tick();
    check("midburst_beats_seen", 256'(n_hs - h0), 256'(2));
    io_reset_n = 1'b0;
    exp_q.delete();
    tick();
    @(negedge io_clock);
    check("midrst_rvalid",  256'(memory_rvalid),  256'(1'b0));
    check("midrst_arready", 256'(memory_arready), 256'(1'b0));
    check("midrst_rdata",   memory_rdata,         256'(0));
    check("midrst_rlast",   256'(memory_rlast),   256'(1'b0));
    tick();
    io_reset_n = 1'b1;
    tick();
    check("midrst_release_arready", 256'(memory_arready), 256'(1'b1));
    for (int k = 0; k < 10; k++) begin
      @(negedge io_clock);
      check("midrst_no_beats", 256'(memory_rvalid), 256'(1'b0));
    end
    send_ar(14'd21, BASE, 8'd3, 3'd5, 2'b01, t);
    wait_drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
